mii_frame_rx: RTL and testbench

//  Parametrised RMII/MII receive front end: packs PHY symbols into bytes, strips
//  the preamble and SFD, and streams frame bytes with sof/vld/eof strobes.

---
 rtl/mii_frame_rx_if.sv | 33 +++
 rtl/mii_frame_rx.sv | 165 ++++++++++++++++
 tb/tb_mii_frame_rx.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_frame_rx_if.sv
// Receive-side bundle for mii_frame_rx: PHY symbol inputs plus the byte stream and eof status.
// master drives the PHY pins and consumes the stream; slave is the receiver itself.
`timescale 1ns/1ps
interface mii_frame_rx_if #(
  parameter int SYM_W = 2,
  parameter int LEN_W = 11
);
  logic             crs_dv;
  logic [SYM_W-1:0] rxd;
  logic             rx_er;
  logic             sof;
  logic             vld;
  logic [7:0]       byte_out;
  logic             eof;
  logic [LEN_W-1:0] len_out;
  logic             err_rxer;
  logic             err_len;
  logic             err_align;
  logic             err_fcs;
  logic             frame_ok;

  modport master (
    output crs_dv, rxd, rx_er,
    input  sof, vld, byte_out, eof, len_out,
    input  err_rxer, err_len, err_align, err_fcs, frame_ok
  );

  modport slave (
    input  crs_dv, rxd, rx_er,
    output sof, vld, byte_out, eof, len_out,
    output err_rxer, err_len, err_align, err_fcs, frame_ok
  );
endinterface

// File: rtl/mii_frame_rx.sv
// RMII/MII receive front end: packs symbols into bytes, strips preamble/SFD, streams frame bytes
// with sof/vld/eof and per-frame status. Define MII_RX_FCS_CHECK_EN to build the CRC-32 FCS check.
`timescale 1ns/1ps
module mii_frame_rx #(
  parameter int SYM_W   = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic           clk50,
  input  logic           rst_n,
  mii_frame_rx_if.slave  bus
);
  localparam int NSYM = 8 / SYM_W;
  localparam int PH_W = $clog2(NSYM);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NSYM - 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, PREAM, DATA, DROP} state_t;

  state_t            state_reg;
  logic              dv_d_reg;
  logic [PH_W-1:0]   phase_reg;
  logic [7:0]        sr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              rxer_reg;
  logic              len_err_reg;
  logic              sof_pend_reg;

  logic              rise;
  logic              fall;
  logic              byte_done;
  logic [7:0]        sr_next;
  logic              eof_len_err;
  logic              eof_align;
  logic              fcs_bad;

  assign rise        = bus.crs_dv & ~dv_d_reg;
  assign fall        = ~bus.crs_dv & dv_d_reg;
  assign sr_next     = {bus.rxd, sr_reg[7:SYM_W]};
  // The rising-edge symbol is always phase 0, so a byte can only finish on a continuing cycle.
  assign byte_done   = bus.crs_dv & dv_d_reg & (phase_reg == PH_LAST);
  assign eof_len_err = len_err_reg | (len_reg < LEN_MIN) | (len_reg > LEN_MAX);
  assign eof_align   = (phase_reg != '0);

`ifdef MII_RX_FCS_CHECK_EN
  logic [31:0] crc_reg;
  logic [31:0] crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (rise) begin
      crc_reg <= '1;
    end else if (byte_done && state_reg == DATA) begin
      crc_reg <= crc_byte(crc_reg, sr_next);
    end
  end

  // The shift register is reflected; the good-frame residue is quoted in normal bit order.
  for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
    assign crc_rev[gi] = crc_reg[31 - gi];
  end

  assign fcs_bad = (crc_rev != 32'hC704DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      dv_d_reg      <= 1'b0;
      phase_reg     <= '0;
      sr_reg        <= '0;
      len_reg       <= '0;
      rxer_reg      <= 1'b0;
      len_err_reg   <= 1'b0;
      sof_pend_reg  <= 1'b0;
      bus.sof       <= 1'b0;
      bus.vld       <= 1'b0;
      bus.byte_out  <= '0;
      bus.eof       <= 1'b0;
      bus.len_out   <= '0;
      bus.err_rxer  <= 1'b0;
      bus.err_len   <= 1'b0;
      bus.err_align <= 1'b0;
      bus.err_fcs   <= 1'b0;
      bus.frame_ok  <= 1'b0;
    end else begin
      bus.sof      <= 1'b0;
      bus.vld      <= 1'b0;
      bus.eof      <= 1'b0;
      bus.frame_ok <= 1'b0;
      dv_d_reg     <= bus.crs_dv;

      if (fall) begin
        phase_reg <= '0;
        if (state_reg == DATA) begin
          bus.eof       <= 1'b1;
          bus.len_out   <= len_reg;
          bus.err_rxer  <= rxer_reg;
          bus.err_len   <= eof_len_err;
          bus.err_align <= eof_align;
          bus.err_fcs   <= fcs_bad;
          bus.frame_ok  <= ~(rxer_reg | eof_len_err | eof_align | fcs_bad);
        end
        state_reg <= IDLE;
      end else if (rise) begin
        state_reg    <= PREAM;
        phase_reg    <= PH_W'(1);
        sr_reg       <= sr_next;
        len_reg      <= '0;
        rxer_reg     <= 1'b0;
        len_err_reg  <= 1'b0;
        sof_pend_reg <= 1'b0;
      end else if (bus.crs_dv) begin
        sr_reg    <= sr_next;
        phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + PH_W'(1);
        case (state_reg)
          PREAM: begin
            if (bus.rx_er) begin
              state_reg <= DROP;
            end else if (byte_done) begin
              if (sr_next == 8'hD5) begin
                state_reg    <= DATA;
                sof_pend_reg <= 1'b1;
              end else if (sr_next != 8'h55) begin
                state_reg <= DROP;
              end
            end
          end
          DATA: begin
            if (bus.rx_er) rxer_reg <= 1'b1;
            if (byte_done) begin
              if (len_reg != LEN_SAT) len_reg <= len_reg + LEN_W'(1);
              // Bytes past MAX_LEN are counted but never emitted.
              if (len_reg < LEN_MAX) begin
                bus.vld      <= 1'b1;
                bus.sof      <= sof_pend_reg;
                bus.byte_out <= sr_next;
                sof_pend_reg <= 1'b0;
              end else begin
                len_err_reg <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mii_frame_rx.sv
// Scoreboard bench for mii_frame_rx: frames are serialised onto the PHY pins while expected bytes
// and eof status are queued; a negedge monitor pops and compares as the receiver produces them.
`timescale 1ns/1ps
module tb_mii_frame_rx;
`ifdef MII_RX_FCS_CHECK_EN
  localparam int SYM_W = 4;
`else
  localparam int SYM_W = 2;
`endif
  localparam int NSYM    = 8 / SYM_W;
  localparam int LEN_W   = 11;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic clk50 = 1'b0;
  logic rst_n;
  always #10 clk50 = ~clk50;

  mii_frame_rx_if #(.SYM_W(SYM_W), .LEN_W(LEN_W)) bus ();

  mii_frame_rx #(.SYM_W(SYM_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct { logic [7:0] data; logic sof; } byte_exp_t;
  typedef struct { int len; logic rxer; logic elen; logic align; logic fcs; logic ok; } stat_exp_t;

  byte_exp_t  byte_q[$];
  stat_exp_t  stat_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] wire_q[$];
  int checks = 0;
  int errors = 0;
  int vld_seen = 0;
  int eof_seen = 0;
  byte_exp_t be;
  stat_exp_t se;

  always @(negedge clk50) begin
    if (rst_n) begin
      if (bus.vld) begin
        vld_seen++;
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld: got byte %02h sof=%b, required no byte", bus.byte_out, bus.sof);
        end else begin
          be = byte_q.pop_front();
          if (bus.byte_out !== be.data || bus.sof !== be.sof) begin
            errors++;
            $display("FAIL byte: got %02h sof=%b, required %02h sof=%b", bus.byte_out, bus.sof, be.data, be.sof);
          end
        end
      end else if (bus.sof) begin
        checks++;
        errors++;
        $display("FAIL sof_without_vld: got sof=1, required 0");
      end
      if (bus.frame_ok && !bus.eof) begin
        checks++;
        errors++;
        $display("FAIL frame_ok_without_eof: got frame_ok=1, required 0");
      end
      if (bus.eof) begin
        eof_seen++;
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_eof: got eof len=%0d, required no eof", bus.len_out);
        end else begin
          se = stat_q.pop_front();
          $display("frame eof len=%0d rxer=%b len_err=%b align=%b fcs=%b ok=%b", bus.len_out,
                   bus.err_rxer, bus.err_len, bus.err_align, bus.err_fcs, bus.frame_ok);
          if (bus.len_out !== LEN_W'(se.len) || bus.err_rxer !== se.rxer || bus.err_len !== se.elen ||
              bus.err_align !== se.align || bus.err_fcs !== se.fcs || bus.frame_ok !== se.ok) begin
            errors++;
            $display("FAIL eof_status: got len=%0d rxer=%b len=%b align=%b fcs=%b ok=%b, required len=%0d rxer=%b len=%b align=%b fcs=%b ok=%b",
                     bus.len_out, bus.err_rxer, bus.err_len, bus.err_align, bus.err_fcs, bus.frame_ok,
                     se.len, se.rxer, se.elen, se.align, se.fcs, se.ok);
          end
        end
      end
    end
  end

  // Payload counts up from 0; the FCS is the inverted CRC-32 appended LSB first.
  task automatic build_frame(input int n_total, input bit flip_last);
    logic [31:0] crc;
    logic [7:0]  b;
    frame_q.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n_total - 4; i++) begin
      b = i[7:0];
      frame_q.push_back(b);
      for (int k = 0; k < 8; k++) begin
        if (crc[0] ^ b[k]) crc = (crc >> 1) ^ 32'hEDB88320;
        else               crc = crc >> 1;
      end
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) frame_q.push_back(crc[8*k +: 8]);
    if (flip_last) frame_q[frame_q.size() - 1] = ~frame_q[frame_q.size() - 1];
  endtask

  task automatic build_wire(input bit good_pream);
    wire_q.delete();
    for (int i = 0; i < 7; i++) wire_q.push_back((good_pream || i != 2) ? 8'h55 : 8'h5D);
    wire_q.push_back(8'hD5);
    foreach (frame_q[i]) wire_q.push_back(frame_q[i]);
  endtask

  task automatic expect_bytes(input int n);
    byte_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = frame_q[i];
      e.sof  = (i == 0);
      byte_q.push_back(e);
    end
  endtask

  task automatic expect_frame(input bit rxer, input bit align, input bit fcs);
    stat_exp_t s;
    int n;
    n = frame_q.size();
    expect_bytes((n > MAX_LEN) ? MAX_LEN : n);
    s.len   = (n > MAX_LEN) ? MAX_LEN + 1 : n;
    s.rxer  = rxer;
    s.elen  = (n < MIN_LEN) || (n > MAX_LEN);
    s.align = align;
    s.fcs   = fcs;
    s.ok    = !(rxer || s.elen || align || fcs);
    stat_q.push_back(s);
  endtask

  task automatic drive_wire(input int er_at, input int extra_syms, input int rst_at, input int gap);
    logic [7:0] b;
    for (int i = 0; i < wire_q.size(); i++) begin
      b = wire_q[i];
      for (int s = 0; s < NSYM; s++) begin
        @(negedge clk50);
        bus.crs_dv = 1'b1;
        bus.rxd    = b[s*SYM_W +: SYM_W];
        bus.rx_er  = (i == er_at) && (s == 0);
        if (i == rst_at && s == 0) begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if ({bus.sof, bus.vld, bus.eof, bus.byte_out, bus.len_out, bus.err_rxer, bus.err_len,
               bus.err_align, bus.err_fcs, bus.frame_ok} !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame_outputs: got sof=%b vld=%b eof=%b len=%0d ok=%b, required all 0",
                     bus.sof, bus.vld, bus.eof, bus.len_out, bus.frame_ok);
          end
          #2 rst_n = 1'b1;
        end
      end
    end
    for (int s = 0; s < extra_syms; s++) begin
      @(negedge clk50);
      bus.rxd   = '1;
      bus.rx_er = 1'b0;
    end
    @(negedge clk50);
    bus.crs_dv = 1'b0;
    bus.rxd    = '0;
    bus.rx_er  = 1'b0;
    repeat (gap - 1) @(negedge clk50);
  endtask

  task automatic end_test(input string name);
    repeat (4) @(negedge clk50);
    checks++;
    if (byte_q.size() !== 0 || stat_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d bytes %0d eofs still pending, required 0", name, byte_q.size(), stat_q.size());
    end
    byte_q.delete();
    stat_q.delete();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.crs_dv = 1'b0;
    bus.rxd    = '0;
    bus.rx_er  = 1'b0;
    repeat (3) @(negedge clk50);
    checks++;
    if ({bus.sof, bus.vld, bus.eof, bus.byte_out, bus.len_out, bus.err_rxer, bus.err_len,
         bus.err_align, bus.err_fcs, bus.frame_ok} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sof=%b vld=%b eof=%b len=%0d ok=%b, required all 0",
               bus.sof, bus.vld, bus.eof, bus.len_out, bus.frame_ok);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);
  endtask

  task automatic test_basic();
    int v0;
    v0 = vld_seen;
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("basic");
    checks++;
    if (vld_seen - v0 !== 64) begin
      errors++;
      $display("FAIL basic_vld_count: got %0d, required 64", vld_seen - v0);
    end
  endtask

  task automatic test_rx_err();
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b1, 1'b0, 1'b0);
    drive_wire(8 + 10, 0, -1, 12);
    end_test("rx_err");
  endtask

  task automatic test_align();
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b1, 1'b0);
    drive_wire(-1, 1, -1, 12);
    end_test("align");
  endtask

  task automatic test_length();
    int v0;
    v0 = vld_seen;
    build_frame(1600, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("oversize");
    checks++;
    if (vld_seen - v0 !== MAX_LEN) begin
      errors++;
      $display("FAIL oversize_vld_count: got %0d, required %0d", vld_seen - v0, MAX_LEN);
    end
    build_frame(20, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("runt");
  endtask

  task automatic test_bad_preamble();
    int v0;
    int e0;
    v0 = vld_seen;
    e0 = eof_seen;
    build_frame(64, 1'b0);
    build_wire(1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("bad_preamble");
    checks++;
    if (vld_seen !== v0 || eof_seen !== e0) begin
      errors++;
      $display("FAIL bad_preamble_output: got %0d vld %0d eof, required 0 and 0", vld_seen - v0, eof_seen - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = eof_seen;
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_bytes(30 - 8);
    drive_wire(-1, 0, 30, 12);
    end_test("reset_mid_frame");
    checks++;
    if (eof_seen !== e0) begin
      errors++;
      $display("FAIL reset_mid_frame_eof: got %0d eof, required 0", eof_seen - e0);
    end
    test_basic();
  endtask

  task automatic test_back_to_back();
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 1);
    build_frame(70, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("back_to_back");
  endtask

`ifdef MII_RX_FCS_CHECK_EN
  task automatic test_fcs();
    build_frame(64, 1'b1);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b1);
    drive_wire(-1, 0, -1, 12);
    end_test("fcs_bad");
    build_frame(64, 1'b0);
    build_wire(1'b1);
    expect_frame(1'b0, 1'b0, 1'b0);
    drive_wire(-1, 0, -1, 12);
    end_test("fcs_good");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rx_err();
    test_align();
    test_length();
    test_bad_preamble();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef MII_RX_FCS_CHECK_EN
    test_fcs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
